// File: rtl/ssp_uart_host_arb.sv
// Round-robin arbiter that turns requests from two host masters (A, B) into single
// SSP register cycles on the ssp_uart slave port, returning read data with a one-cycle Ack.
module ssp_uart_host_arb #(
  parameter int HOLD_CYC = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        A_Req,
  input  logic        A_WnR,
  input  logic [2:0]  A_RA,
  input  logic [11:0] A_DI,
  output logic        A_Ack,
  input  logic        B_Req,
  input  logic        B_WnR,
  input  logic [2:0]  B_RA,
  input  logic [11:0] B_DI,
  output logic        B_Ack,
  output logic [11:0] Rsp_DO,
  output logic        Rsp_Err,
  output logic        Busy,
  output logic        Gnt_B,
  output logic        SSP_SSEL,
  output logic [2:0]  SSP_RA,
  output logic        SSP_WnR,
  output logic [11:0] SSP_DI,
  output logic        SSP_EOC,
  input  logic [11:0] SSP_DO
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] HOLD  = 3'd2;
  localparam logic [2:0] EOC   = 3'd3;
  localparam logic [2:0] ACK   = 3'd4;
  localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_wnr;
  logic [2:0]  r_ra;
  logic [11:0] r_di;
  logic        r_gnt_b;
  logic        r_a_ack, r_b_ack, r_rsp_err, r_busy, r_ssel, r_ssp_wnr, r_eoc;
  logic [11:0] r_rsp_do, r_ssp_di;
  logic [2:0]  r_ssp_ra;

  logic [2:0]  w_nxt;
  logic        w_grant, w_gnt_b, w_wnr, w_err, w_bus;
  logic [2:0]  w_ra;
  logic [11:0] w_di;

  always_comb begin
    w_nxt   = r_state;
    w_grant = 1'b0;
    w_gnt_b = r_gnt_b;
    w_wnr   = r_wnr;
    w_ra    = r_ra;
    w_di    = r_di;
    w_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (A_Req || B_Req) begin
          w_grant = 1'b1;
          // The pointer holds the last winner, so on contention the other side goes next.
          w_gnt_b = (A_Req && B_Req) ? ~r_gnt_b : B_Req;
          w_wnr   = w_gnt_b ? B_WnR : A_WnR;
          w_ra    = w_gnt_b ? B_RA  : A_RA;
          w_di    = w_gnt_b ? B_DI  : A_DI;
          w_err   = (w_ra > 3'd4);
          w_nxt   = w_err ? ACK : SETUP;
        end
      end
      SETUP:   w_nxt = (HOLD_LD == 4'd0) ? EOC : HOLD;
      HOLD:    if (r_cnt == 4'd1) w_nxt = EOC;
      EOC:     w_nxt = ACK;
      ACK:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    w_bus = (w_nxt == SETUP) || (w_nxt == HOLD) || (w_nxt == EOC);
  end

  // Every output is computed from the next state so that it leaves a flop directly.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wnr     <= 1'b0;
      r_ra      <= '0;
      r_di      <= '0;
      r_gnt_b   <= 1'b1;
      r_a_ack   <= 1'b0;
      r_b_ack   <= 1'b0;
      r_rsp_do  <= '0;
      r_rsp_err <= 1'b0;
      r_busy    <= 1'b0;
      r_ssel    <= 1'b0;
      r_ssp_ra  <= '0;
      r_ssp_wnr <= 1'b0;
      r_ssp_di  <= '0;
      r_eoc     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_grant) begin
        r_wnr   <= w_wnr;
        r_ra    <= w_ra;
        r_di    <= w_di;
        r_gnt_b <= w_gnt_b;
      end
      if (r_state == SETUP)
        r_cnt <= HOLD_LD;
      else if ((r_state == HOLD) && (r_cnt != 4'd1))
        r_cnt <= r_cnt - 4'd1;
      r_a_ack   <= (w_nxt == ACK) && !w_gnt_b;
      r_b_ack   <= (w_nxt == ACK) && w_gnt_b;
      r_rsp_err <= w_err;
      // Read data is taken on the edge that closes the EOC cycle.
      r_rsp_do  <= ((r_state == EOC) && !r_wnr) ? SSP_DO : 12'd0;
      r_busy    <= (w_nxt != IDLE);
      r_ssel    <= w_bus;
      r_eoc     <= (w_nxt == EOC);
      r_ssp_ra  <= w_bus ? w_ra  : 3'd0;
      r_ssp_wnr <= w_bus ? w_wnr : 1'b0;
      r_ssp_di  <= w_bus ? w_di  : 12'd0;
    end
  end

  assign A_Ack    = r_a_ack;
  assign B_Ack    = r_b_ack;
  assign Rsp_DO   = r_rsp_do;
  assign Rsp_Err  = r_rsp_err;
  assign Busy     = r_busy;
  assign Gnt_B    = r_gnt_b;
  assign SSP_SSEL = r_ssel;
  assign SSP_RA   = r_ssp_ra;
  assign SSP_WnR  = r_ssp_wnr;
  assign SSP_DI   = r_ssp_di;
  assign SSP_EOC  = r_eoc;

endmodule

// File: tb/tb_ssp_uart_host_arb.sv
// Randomized bench for ssp_uart_host_arb: two instances (HOLD_CYC 2 and 0) with an SSP
// register-file slave, checked cycle by cycle against a transaction-timeline model.
module tb_ssp_uart_host_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][1:0]       req, wnr, ack;
  logic [1:0][1:0][2:0]  ra;
  logic [1:0][1:0][11:0] di;
  logic [1:0][11:0]      rsp_do, ssp_di, ssp_do;
  logic [1:0]            rsp_err, busy, gnt_b, ssel, eoc, ssp_wnr;
  logic [1:0][2:0]       ssp_ra;

  for (genvar u = 0; u < 2; u++) begin : g_dut
    logic [11:0] smem [8] = '{default: 12'd0};

    ssp_uart_host_arb #(.HOLD_CYC(u == 0 ? 2 : 0)) dut (
      .Clk(clk), .Rst(rst),
      .A_Req(req[u][0]), .A_WnR(wnr[u][0]), .A_RA(ra[u][0]), .A_DI(di[u][0]), .A_Ack(ack[u][0]),
      .B_Req(req[u][1]), .B_WnR(wnr[u][1]), .B_RA(ra[u][1]), .B_DI(di[u][1]), .B_Ack(ack[u][1]),
      .Rsp_DO(rsp_do[u]), .Rsp_Err(rsp_err[u]), .Busy(busy[u]), .Gnt_B(gnt_b[u]),
      .SSP_SSEL(ssel[u]), .SSP_RA(ssp_ra[u]), .SSP_WnR(ssp_wnr[u]), .SSP_DI(ssp_di[u]),
      .SSP_EOC(eoc[u]), .SSP_DO(ssp_do[u])
    );

    always @(posedge clk) if (eoc[u] && ssp_wnr[u]) smem[ssp_ra[u]] <= ssp_di[u];
    assign ssp_do[u] = smem[ssp_ra[u]];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int u, input int m,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d cyc%0d got %0h want %0h", tag, u, m, act, exp);
    end
  endtask

  // Reference model: one record for the latest granted transaction per instance,
  // its output windows derived from the grant edge with plain arithmetic.
  int          hc    [2] = '{2, 0};
  int          nfree [2];
  bit          cv    [2];
  int          cg    [2];
  bit          cwho  [2];
  bit          cwnr  [2];
  bit          cerr  [2];
  logic [2:0]  cra   [2];
  logic [11:0] cdi   [2];
  bit          ptr   [2];
  logic [11:0] mmem  [2][8];
  bit [1:0]    acked [2];

  task automatic check_cycle(input int u, input int m);
    bit e_ssel, e_eoc, e_ack, e_busy;
    int d;
    logic [11:0] e_do;
    e_ssel = 1'b0; e_eoc = 1'b0; e_ack = 1'b0; e_busy = 1'b0;
    if (cv[u]) begin
      d = m - cg[u];
      if (cerr[u]) begin
        e_ack  = (d == 0);
        e_busy = (d == 0);
      end else begin
        e_ssel = (d >= 0) && (d <= hc[u] + 1);
        e_eoc  = (d == hc[u] + 1);
        e_ack  = (d == hc[u] + 2);
        e_busy = (d >= 0) && (d <= hc[u] + 2);
      end
    end
    chk("ssel",  u, m, 32'(ssel[u]),    32'(e_ssel));
    chk("eoc",   u, m, 32'(eoc[u]),     32'(e_eoc));
    chk("busy",  u, m, 32'(busy[u]),    32'(e_busy));
    chk("gnt_b", u, m, 32'(gnt_b[u]),   32'(ptr[u]));
    chk("ssp_ra",  u, m, 32'(ssp_ra[u]),  e_ssel ? 32'(cra[u])  : 32'd0);
    chk("ssp_wnr", u, m, 32'(ssp_wnr[u]), e_ssel ? 32'(cwnr[u]) : 32'd0);
    chk("ssp_di",  u, m, 32'(ssp_di[u]),  e_ssel ? 32'(cdi[u])  : 32'd0);
    chk("a_ack", u, m, 32'(ack[u][0]), 32'(e_ack && !cwho[u]));
    chk("b_ack", u, m, 32'(ack[u][1]), 32'(e_ack && cwho[u]));
    acked[u] = 2'b00;
    if (e_ack) begin
      acked[u][cwho[u]] = 1'b1;
      e_do = (cerr[u] || cwnr[u]) ? 12'd0 : mmem[u][cra[u]];
      chk("rsp_err", u, m, 32'(rsp_err[u]), 32'(cerr[u]));
      chk("rsp_do",  u, m, 32'(rsp_do[u]),  32'(e_do));
      if (!cerr[u] && cwnr[u]) mmem[u][cra[u]] = cdi[u];
    end
  endtask

  task automatic new_txn(input int u, input int r);
    req[u][r] = 1'b1;
    wnr[u][r] = 1'($urandom_range(0, 1));
    ra[u][r]  = 3'($urandom_range(0, 7));
    di[u][r]  = 12'($urandom_range(0, 4095));
  endtask

  // Requesters: hold a request until Ack, then either drop or go back-to-back.
  task automatic drive(input int u, input int m);
    for (int r = 0; r < 2; r++) begin
      if (acked[u][r]) begin
        if (m > 1500 || $urandom_range(0, 2) == 0) new_txn(u, r);
        else req[u][r] = 1'b0;
      end else if (!req[u][r] && $urandom_range(0, 3) == 0) begin
        new_txn(u, r);
      end
    end
  endtask

  task automatic model_edge(input int u, input int e);
    bit w;
    if (e >= nfree[u] && (req[u][0] || req[u][1])) begin
      w = (req[u][0] && req[u][1]) ? ~ptr[u] : req[u][1];
      ptr[u]  = w;
      cv[u]   = 1'b1;
      cg[u]   = e;
      cwho[u] = w;
      cwnr[u] = wnr[u][w];
      cra[u]  = ra[u][w];
      cdi[u]  = di[u][w];
      cerr[u] = (ra[u][w] > 3'd4);
      nfree[u] = cerr[u] ? e + 2 : e + hc[u] + 4;
    end
  endtask

  int m;

  initial begin
    req = '0; wnr = '0; ra = '0; di = '0;
    for (int u = 0; u < 2; u++) begin
      ptr[u] = 1'b1; cv[u] = 1'b0; acked[u] = 2'b00;
      for (int i = 0; i < 8; i++) mmem[u][i] = 12'd0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_busy",  u, 0, 32'(busy[u]),  32'd0);
      chk("rst_gnt_b", u, 0, 32'(gnt_b[u]), 32'd1);
      chk("rst_ssel",  u, 0, 32'(ssel[u]),  32'd0);
      chk("rst_eoc",   u, 0, 32'(eoc[u]),   32'd0);
      chk("rst_ack",   u, 0, 32'(ack[u]),   32'd0);
      chk("rst_do",    u, 0, 32'(rsp_do[u]), 32'd0);
      chk("rst_ra",    u, 0, 32'(ssp_ra[u]), 32'd0);
    end
    rst = 1'b0;
    m = 0;
    for (int u = 0; u < 2; u++) begin
      nfree[u] = 1;
      drive(u, m);
      model_edge(u, 1);
    end
    for (int it = 0; it < 3000; it++) begin
      @(posedge clk);
      m++;
      if (it > 20 && $urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
          chk("async_ssel", u, m, 32'(ssel[u]), 32'd0);
          chk("async_eoc",  u, m, 32'(eoc[u]),  32'd0);
          chk("async_ack",  u, m, 32'(ack[u]),  32'd0);
        end
        #1 rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
          cv[u] = 1'b0; ptr[u] = 1'b1; nfree[u] = m + 1;
        end
      end
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        check_cycle(u, m);
        drive(u, m);
        model_edge(u, m + 1);
      end
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ssp_uart_host_arb.md
# ssp_uart_host_arb

Round-robin arbiter and bus sequencer that shares the ssp_uart SSP register port (UCR/USR/TDR/RDR/SPR) between two on-chip requesters, A and B. Each granted request becomes exactly one SSP read or write cycle: SSP_SSEL is asserted, held for a fixed number of cycles, and the cycle is closed with an SSP_EOC strobe. Read data is returned to the winning requester with a one-cycle acknowledge. The block sits between the host-side masters (configuration loader, data mover) and the ssp_uart SSP slave port.

## Interface
- HOLD_CYC, 2, number of cycles SSP_SSEL stays asserted between the setup cycle and the EOC cycle; legal range 0..15.

- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- A_Req  in  1  requester A transaction request (level).
- A_WnR  in  1  A direction: 1 = write, 0 = read.
- A_RA  in  3  A register address.
- A_DI  in  12  A write data.
- A_Ack  out  1  one-cycle completion pulse to A.
- B_Req, B_WnR, B_RA, B_DI, B_Ack: same as A, for requester B.
- Rsp_DO  out  12  read data for the acknowledged transaction; valid only while an Ack is high.
- Rsp_Err  out  1  illegal-address flag; valid only while an Ack is high.
- Busy  out  1  high whenever the FSM is not in IDLE.
- Gnt_B  out  1  current or most recent owner: 0 = A, 1 = B.
- SSP_SSEL  out  1  SSP slave select.
- SSP_RA  out  3  SSP register address.
- SSP_WnR  out  1  SSP direction.
- SSP_DI  out  12  SSP write data.
- SSP_EOC  out  1  SSP end-of-cycle strobe.
- SSP_DO  in  12  SSP read data from ssp_uart.

## Operation
- FSM states: IDLE, SETUP, HOLD, EOC, ACK.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester not granted last. The last-grant pointer resets to B, so A wins first.
  - On grant, latch WnR, RA and DI, and update Gnt_B.
  - If the latched RA is 0..4, go to SETUP.
  - If RA is 5..7, go directly to ACK with the error flag set. No SSP cycle is issued.
- **SETUP** (1 cycle)
  - SSP_SSEL = 1; SSP_RA, SSP_WnR and SSP_DI driven from the latched values.
  - Load the hold counter with HOLD_CYC.
  - Go to HOLD, or to EOC when HOLD_CYC = 0.
- **HOLD**
  - SSEL and the latched bus values stay driven.
  - Counter decrements once per cycle; leave for EOC when it reaches 1.
  - Total time in HOLD is exactly HOLD_CYC cycles.
- **EOC** (1 cycle)
  - SSEL = 1 and SSP_EOC = 1.
  - For a read, capture SSP_DO on the rising edge that ends this cycle.
  - Go to ACK.
- **ACK** (1 cycle)
  - SSEL = 0. The granted requester's Ack = 1.
  - Rsp_DO = captured data for reads; 0 for writes and for errors.
  - Rsp_Err = 1 only for illegal addresses.
  - Request inputs are ignored in this cycle. Go to IDLE.
- Requester rule: drop Req in the cycle after Ack is seen. If Req is still high in IDLE, it is a new request (back-to-back transactions are legal).
- Request inputs must be stable from Req assertion until Ack. Changes after the grant have no effect.
- Outside SETUP, HOLD and EOC, the SSP_RA, SSP_WnR and SSP_DI outputs are 0.
- SSP_SSEL is high only in SETUP, HOLD and EOC. SSP_EOC is high only in EOC.

## Timing
- All outputs are registered. Reset value of every output is 0, except Gnt_B, which resets to 1.
- Rst assertion: all state and outputs clear immediately, including mid-transaction (SSEL and EOC drop without waiting for Clk).
  - No Ack is issued for an aborted transaction.
  - The pointer returns to its reset value.
- Request sampled high at IDLE edge k:
  - SSEL rises after edge k.
  - EOC is high in the cycle after edge k+1+HOLD_CYC.
  - Ack is high in the cycle after edge k+2+HOLD_CYC.
  - FSM is back in IDLE after edge k+3+HOLD_CYC.
- SSEL width is HOLD_CYC+2 cycles (setup + hold + EOC).
- Minimum spacing between grants: HOLD_CYC+4 cycles.
- Illegal-address request: Ack in the cycle after the grant edge; the next grant follows 2 cycles after that grant edge.
- Simultaneous Req from A and B while busy: both wait; resolved in IDLE by the pointer. Strict alternation while both are held.

## Test plan
- **Reset:** Rst=1 then 0 with no requests → all outputs 0, Gnt_B=1, Busy=0, SSP_SSEL never rises.
- **A write UCR** (A_Req, WnR=1, RA=0, DI=0xDED, HOLD_CYC=2):
  - SSEL high 4 cycles; EOC in the 4th cycle with RA=0, DI=0xDED.
  - A_Ack one cycle later with Rsp_DO=0.
  - A following A read of UCR (slave model returns 0xDED) → Rsp_DO=0xDED with A_Ack.
- **Contention:** A (write TDR=0x0F1) and B (read USR) both held from reset → grant order A, B, A, B. Each SSEL burst is separated by exactly 1 idle cycle, and Gnt_B toggles every transaction.
- **Illegal address:** B_Req with RA=7 → SSEL never asserts; B_Ack 1 cycle after the grant edge with Rsp_Err=1 and Rsp_DO=0. A subsequent legal B read is unaffected.
- **Reset mid-HOLD:** Rst pulsed during A's HOLD state → SSEL and EOC drop asynchronously and no A_Ack. After release, A's still-held Req restarts from SETUP with the same RA/DI.
- **HOLD_CYC=0, back-to-back:** A holds Req for 3 writes to TDR (0x0F1..0x0F3) → each SSEL burst is 2 cycles, with Acks every 4 cycles and data values in order.
